sfifo: RTL

//  Parametrised single-clock FIFO; successor to the dual-clock FIFO used in the BIU. Intended for

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/sfifo_mem.sv | 23 ++
 rtl/sfifo.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode encodings
// and the width helper used to size occupancy counters.
package fifo_pkg;

    localparam logic FIFO_MODE_STD  = 1'b0;
    localparam logic FIFO_MODE_FWFT = 1'b1;

    // Smallest r with 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // A counter that must hold 0..2**ptr inclusive.
    function automatic int cnt_width(input int ptr);
        return clog2((1 << ptr) + 1);
    endfunction

endpackage

// File: rtl/sfifo_mem.sv
// FIFO storage: 2**PTR x WIDTH register array with one synchronous write
// port and one asynchronous read port. Contents are never reset.
module sfifo_mem #(
    parameter int WIDTH = 16,
    parameter int PTR   = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [PTR-1:0]   waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [PTR-1:0]   raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [2**PTR];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sfifo.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// registered occupancy/threshold flags, sticky overflow/underflow and sync flush.
module sfifo
    import fifo_pkg::*;
#(
    parameter int   WIDTH     = 16,
    parameter int   PTR       = 4,
    parameter int   AFULL_TH  = 14,
    parameter int   AEMPTY_TH = 2,
    parameter logic FWFT      = FIFO_MODE_STD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_full,
    output logic             wr_afull,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_empty,
    output logic             rd_aempty,
    output logic [PTR:0]     data_cnt,
    output logic             overflow,
    output logic             underflow
);

    localparam int              CNT_W     = cnt_width(PTR);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(2**PTR);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_TH);

    logic [PTR-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, afull_q, empty_q, aempty_q;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             wr_acc, rd_acc;
    logic [WIDTH-1:0] mem_rdata;

    // Acceptance looks only at registered flags, so a full FIFO never passes
    // a same-cycle write through to a same-cycle read.
    assign wr_acc = wr_en & ~full_q  & ~clr;
    assign rd_acc = rd_en & ~empty_q & ~clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | (wr_en & full_q);
        udf_d    = udf_q | (rd_en & empty_q);
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == DEPTH_C);
            afull_q  <= (cnt_d >= AFULL_C);
            empty_q  <= (cnt_d == '0);
            aempty_q <= (cnt_d <= AEMPTY_C);
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Gating with rst_n keeps a write from landing while reset is asserted.
    sfifo_mem #(.WIDTH(WIDTH), .PTR(PTR)) u_mem (
        .clk     (clk),
        .we_i    (wr_acc & rst_n),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_STD) begin : g_std
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) rd_data_q <= mem_rdata;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end else begin : g_fwft
            assign rd_data  = mem_rdata;
            assign rd_valid = ~empty_q;
        end
    endgenerate

    assign wr_full   = full_q;
    assign wr_afull  = afull_q;
    assign rd_empty  = empty_q;
    assign rd_aempty = aempty_q;
    assign data_cnt  = cnt_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule
